// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode control, instruction memory port, decode-side
// output register and FSM debug state.
interface fetch_stage_if;
  // Memory handshake: im_req is the valid and im_ready the same-cycle ready.
  // A word transfers on any edge where both are high; im_rdata is only
  // meaningful in that cycle, and im_addr stays stable until the transfer.
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        insn_valid;
  logic        addr_err;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  modport master (
    input  stall, redirect, target, im_ready, im_rdata,
    output im_req, im_addr, pc, insn, insn_valid, addr_err, fetch_count, dbg_state
  );

  modport slave (
    output stall, redirect, target, im_ready, im_rdata,
    input  im_req, im_addr, pc, insn, insn_valid, addr_err, fetch_count, dbg_state
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, single-cycle memory port, registered
// pc/insn slot to decode with stall back-pressure and branch redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] fpc_q;
  logic [31:0] pc_q;
  logic [31:0] insn_q;
  logic        valid_q;
  logic        addr_err_q;
  logic [31:0] count_q;

  logic slot_free;
  logic req;
  logic accept;

  // The slot can take a new word when it is empty or decode drains it now.
  assign slot_free = !valid_q || !bus.stall;
  assign req       = (state_q == REQ) && slot_free;
  assign accept    = req && bus.im_ready && !bus.redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      pc_q       <= 32'd0;
      insn_q     <= 32'd0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      count_q    <= 32'd0;
    end else if (bus.redirect) begin
      // Redirect wins over stall and any same-cycle memory response.
      state_q <= REQ;
      fpc_q   <= {bus.target[31:2], 2'b00};
      valid_q <= 1'b0;
      if (bus.target[1:0] != 2'b00) begin
        addr_err_q <= 1'b1;
      end
    end else begin
      if (accept) begin
        pc_q    <= fpc_q;
        insn_q  <= bus.im_rdata;
        valid_q <= 1'b1;
        fpc_q   <= fpc_q + 32'd4;
        count_q <= count_q + 32'd1;
      end else if (valid_q && !bus.stall) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (accept && bus.stall) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.im_req      = req;
  assign bus.im_addr     = fpc_q;
  assign bus.pc          = pc_q;
  assign bus.insn        = insn_q;
  assign bus.insn_valid  = valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.fetch_count = count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: accepted fetch addresses are queued as
// stimulus is issued; a negedge monitor checks each accept and its delivery.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h8002_0000;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic clock;
  logic reset;
  fetch_stage_if bus_if ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: word is a fixed scramble of its address.
  assign bus_if.im_rdata = bus_if.im_addr ^ KEY;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  // Monitor: each accepted request must match the next queued address, and
  // the following cycle must present that word in the output register.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  always @(negedge clock) begin
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("out_pc", bus_if.pc, pend_addr);
        chk("out_insn", bus_if.insn, pend_addr ^ KEY);
        chk("out_valid", {31'd0, bus_if.insn_valid}, 32'd1);
        pend = 1'b0;
      end
      if (bus_if.im_req && bus_if.im_ready && !bus_if.redirect) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", bus_if.im_addr, 32'hDEAD_DEAD);
        end else begin
          pend_addr = exp_q.pop_front();
          chk("accept_addr", bus_if.im_addr, pend_addr);
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver
  initial begin
    reset = 1'b1;
    bus_if.stall    = 1'b0;
    bus_if.redirect = 1'b0;
    bus_if.target   = 32'd0;
    bus_if.im_ready = 1'b0;

    nc();
    mid();
    chk("rst_pc", bus_if.pc, 32'd0);
    chk("rst_insn", bus_if.insn, 32'd0);
    chk("rst_valid", {31'd0, bus_if.insn_valid}, 32'd0);
    chk("rst_count", bus_if.fetch_count, 32'd0);
    chk("rst_aerr", {31'd0, bus_if.addr_err}, 32'd0);
    chk("rst_req", {31'd0, bus_if.im_req}, 32'd0);
    chk("rst_state", {30'd0, bus_if.dbg_state}, 32'd0);
    chk("rst_addr", bus_if.im_addr, RPC);

    // Sequential fetch from reset PC
    nc();
    reset = 1'b0;
    bus_if.im_ready = 1'b1;
    exp_q.push_back(32'h8002_0000);
    exp_q.push_back(32'h8002_0004);
    exp_q.push_back(32'h8002_0008);
    mid();
    chk("c1_req", {31'd0, bus_if.im_req}, 32'd0);
    chk("c1_state", {30'd0, bus_if.dbg_state}, 32'd0);
    nc();
    mid();
    chk("c2_req", {31'd0, bus_if.im_req}, 32'd1);
    chk("c2_addr", bus_if.im_addr, 32'h8002_0000);
    chk("c2_valid", {31'd0, bus_if.insn_valid}, 32'd0);
    nc();
    mid();
    chk("c3_valid", {31'd0, bus_if.insn_valid}, 32'd1);
    nc();
    nc();

    // Stall three cycles with pc 8002_0008 in the slot
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("stall_req", {31'd0, bus_if.im_req}, 32'd0);
      chk("stall_pc", bus_if.pc, 32'h8002_0008);
      chk("stall_insn", bus_if.insn, 32'h8002_0008 ^ KEY);
      chk("stall_valid", {31'd0, bus_if.insn_valid}, 32'd1);
      nc();
    end
    bus_if.stall = 1'b0;
    exp_q.push_back(32'h8002_000C);
    exp_q.push_back(32'h8002_0010);
    mid();
    chk("rel_addr", bus_if.im_addr, 32'h8002_000C);
    chk("rel_req", {31'd0, bus_if.im_req}, 32'd1);
    nc();
    nc();

    // Memory not ready for four cycles
    bus_if.im_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("wait_req", {31'd0, bus_if.im_req}, 32'd1);
      chk("wait_addr", bus_if.im_addr, 32'h8002_0014);
      chk("wait_count", bus_if.fetch_count, 32'd5);
      if (i > 0) chk("wait_valid", {31'd0, bus_if.insn_valid}, 32'd0);
      nc();
    end
    bus_if.im_ready = 1'b1;
    exp_q.push_back(32'h8002_0014);
    mid();
    chk("retry_addr", bus_if.im_addr, 32'h8002_0014);
    nc();

    // Redirect together with stall and im_ready
    bus_if.redirect = 1'b1;
    bus_if.target   = 32'h0040_0100;
    bus_if.stall    = 1'b1;
    mid();
    chk("rd1_req", {31'd0, bus_if.im_req}, 32'd0);
    nc();
    bus_if.redirect = 1'b0;
    exp_q.push_back(32'h0040_0100);
    mid();
    chk("rd1_valid", {31'd0, bus_if.insn_valid}, 32'd0);
    chk("rd1_addr", bus_if.im_addr, 32'h0040_0100);
    chk("rd1_req2", {31'd0, bus_if.im_req}, 32'd1);
    chk("rd1_aerr", {31'd0, bus_if.addr_err}, 32'd0);
    chk("rd1_count", bus_if.fetch_count, 32'd6);
    nc();
    mid();
    chk("hold_state", {30'd0, bus_if.dbg_state}, 32'd2);
    chk("hold_req", {31'd0, bus_if.im_req}, 32'd0);
    chk("hold_count", bus_if.fetch_count, 32'd7);
    nc();
    bus_if.stall = 1'b0;
    mid();
    chk("hold_rel_req", {31'd0, bus_if.im_req}, 32'd0);
    chk("hold_rel_valid", {31'd0, bus_if.insn_valid}, 32'd1);
    nc();

    // Misaligned redirect while a response is being returned
    bus_if.redirect = 1'b1;
    bus_if.target   = 32'h0040_0102;
    mid();
    chk("rd2_req", {31'd0, bus_if.im_req}, 32'd1);
    chk("rd2_valid", {31'd0, bus_if.insn_valid}, 32'd0);
    chk("rd2_state", {30'd0, bus_if.dbg_state}, 32'd1);
    nc();
    bus_if.redirect = 1'b0;
    exp_q.push_back(32'h0040_0100);
    exp_q.push_back(32'h0040_0104);
    exp_q.push_back(32'h0040_0108);
    mid();
    chk("rd2_addr", bus_if.im_addr, 32'h0040_0100);
    chk("rd2_aerr", {31'd0, bus_if.addr_err}, 32'd1);
    chk("rd2_count", bus_if.fetch_count, 32'd7);
    chk("rd2_valid2", {31'd0, bus_if.insn_valid}, 32'd0);
    nc();
    nc();
    nc();

    // Redirect to top of address space, check wrap
    bus_if.redirect = 1'b1;
    bus_if.target   = 32'hFFFF_FFFC;
    mid();
    chk("seq_count", bus_if.fetch_count, 32'd10);
    chk("seq_aerr", {31'd0, bus_if.addr_err}, 32'd1);
    chk("seq_pc", bus_if.pc, 32'h0040_0108);
    nc();
    bus_if.redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    mid();
    chk("wrap_top", bus_if.im_addr, 32'hFFFF_FFFC);
    nc();
    mid();
    chk("wrap_zero", bus_if.im_addr, 32'h0000_0000);
    nc();
    chk("wrap_count", bus_if.fetch_count, 32'd12);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pc", bus_if.pc, 32'd0);
    chk("ar_insn", bus_if.insn, 32'd0);
    chk("ar_valid", {31'd0, bus_if.insn_valid}, 32'd0);
    chk("ar_count", bus_if.fetch_count, 32'd0);
    chk("ar_aerr", {31'd0, bus_if.addr_err}, 32'd0);
    chk("ar_req", {31'd0, bus_if.im_req}, 32'd0);
    chk("ar_addr", bus_if.im_addr, RPC);
    mid();
    nc();
    reset = 1'b0;
    exp_q.push_back(32'h8002_0000);
    mid();
    chk("rr_req", {31'd0, bus_if.im_req}, 32'd0);
    chk("rr_state", {30'd0, bus_if.dbg_state}, 32'd0);
    nc();
    mid();
    chk("rr_req2", {31'd0, bus_if.im_req}, 32'd1);
    chk("rr_addr", bus_if.im_addr, RPC);
    nc();
    bus_if.im_ready = 1'b0;
    mid();
    chk("rr_count", bus_if.fetch_count, 32'd1);
    chk("rr_valid", {31'd0, bus_if.insn_valid}, 32'd1);
    nc();
    nc();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
